// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus master: CA phase, fixed/variable initial latency, linear burst read/write,
// byte-masked writes, zero-latency register writes and read timeout recovery.
module hyperbus_burst_ctrl #(
   parameter int TACC_COUNT    = 6,
   parameter int FIXED_LATENCY = 0,
   parameter int MAX_BURST     = 16,
   parameter int RESET_COUNT   = 4,
   parameter int TIMEOUT       = 64,
   parameter int CSHI_COUNT    = 2,
   localparam int LW           = $clog2(MAX_BURST)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic          req_reg,
   input  logic [31:0]   req_adr,
   input  logic [LW-1:0] req_len_m1,
   input  logic          wdat_valid,
   output logic          wdat_ready,
   input  logic [15:0]   wdat,
   input  logic [1:0]    wmask,
   output logic          rdat_valid,
   output logic [15:0]   rdat,
   output logic          done,
   output logic [1:0]    status,
   output logic          hbus_ck,
   output logic          hbus_rstn,
   output logic          hbus_csn,
   output logic [7:0]    hbus_dq_o,
   output logic          hbus_dq_oe,
   input  logic [7:0]    hbus_dq_i,
   output logic          hbus_rwds_o,
   output logic          hbus_rwds_oe,
   input  logic          hbus_rwds_i
);

   localparam int CW = $clog2(4*TACC_COUNT + RESET_COUNT + CSHI_COUNT + 8);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_RESET, S_IDLE, S_CMD, S_LAT, S_WRITE, S_READ, S_GAP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic [47:0]     ca_q;
   logic            we_q, reg_q, lat2x;
   logic [LW-1:0]   len_q, wcnt;
   logic            wph;
   logic [7:0]      wlo, rd_hi;
   logic            mlo;
   logic [TW-1:0]   tmo;
   logic            rwds_prev, rwds_edge;
   logic            ck_q;
   logic            fin;
   logic [1:0]      fin_st;
   logic [CW-1:0]   lat_last;

   assign rwds_edge = hbus_rwds_i ^ rwds_prev;
   assign lat_last  = lat2x ? CW'(4*TACC_COUNT - 1) : CW'(2*TACC_COUNT - 1);
   assign hbus_rstn = (state != S_RESET);
   assign hbus_ck   = ck_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RESET;
      else     state <= state_n;
   end

   always_comb begin
      state_n      = state;
      req_ready    = 1'b0;
      wdat_ready   = 1'b0;
      hbus_csn     = 1'b1;
      hbus_dq_oe   = 1'b0;
      hbus_rwds_oe = 1'b0;
      hbus_dq_o    = 8'h00;
      hbus_rwds_o  = 1'b0;
      fin          = 1'b0;
      fin_st       = 2'b00;
      case (state)
         S_RESET: if (cnt == CW'(RESET_COUNT - 1)) state_n = S_IDLE;
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_n = S_CMD;
         end
         S_CMD: begin
            hbus_csn   = 1'b0;
            hbus_dq_oe = 1'b1;
            hbus_dq_o  = ca_q[47:40];
            if (cnt == CW'(5)) state_n = (we_q && reg_q) ? S_WRITE : S_LAT;
         end
         S_LAT: begin
            hbus_csn = 1'b0;
            if (cnt == lat_last) state_n = we_q ? S_WRITE : S_READ;
         end
         S_WRITE: begin
            hbus_csn     = 1'b0;
            hbus_dq_oe   = 1'b1;
            hbus_rwds_oe = ~reg_q;
            if (!wph) begin
               if (wdat_valid) begin
                  wdat_ready  = 1'b1;
                  hbus_dq_o   = wdat[15:8];
                  hbus_rwds_o = wmask[1];
               end else begin
                  // underrun: mask the dead beat and close the burst
                  hbus_rwds_o = 1'b1;
                  fin         = 1'b1;
                  fin_st      = 2'b10;
                  state_n     = S_GAP;
               end
            end else begin
               hbus_dq_o   = wlo;
               hbus_rwds_o = mlo;
               if (wcnt == len_q) begin
                  fin     = 1'b1;
                  state_n = S_GAP;
               end
            end
         end
         S_READ: begin
            hbus_csn = 1'b0;
            if (rwds_edge) begin
               if (!hbus_rwds_i && wcnt == len_q) begin
                  fin     = 1'b1;
                  state_n = S_GAP;
               end
            end else if (tmo == TW'(1)) begin
               fin     = 1'b1;
               fin_st  = 2'b01;
               state_n = S_GAP;
            end
         end
         S_GAP: if (cnt == CW'(CSHI_COUNT - 1)) state_n = S_IDLE;
         default: state_n = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         ca_q       <= '0;
         we_q       <= 1'b0;
         reg_q      <= 1'b0;
         len_q      <= '0;
         lat2x      <= 1'b0;
         wcnt       <= '0;
         wph        <= 1'b0;
         wlo        <= 8'h00;
         mlo        <= 1'b0;
         rd_hi      <= 8'h00;
         tmo        <= '0;
         rwds_prev  <= 1'b0;
         ck_q       <= 1'b0;
         rdat       <= 16'h0000;
         rdat_valid <= 1'b0;
         done       <= 1'b0;
         status     <= 2'b00;
      end else begin
         cnt       <= (state_n != state) ? '0 : cnt + 1'b1;
         rwds_prev <= hbus_rwds_i;
         // CK only runs while staying inside the active phases, so it starts and ends low
         ck_q       <= (state inside {S_CMD, S_LAT, S_WRITE, S_READ} &&
                        state_n inside {S_CMD, S_LAT, S_WRITE, S_READ}) ? ~ck_q : 1'b0;
         rdat_valid <= (state == S_READ) && rwds_edge && !hbus_rwds_i;
         done       <= fin;
         if (fin) status <= fin_st;

         if (state == S_IDLE && req_valid) begin
            ca_q  <= {~req_we, req_reg, 1'b1, req_adr[31:3], 13'h0000, req_adr[2:0]};
            we_q  <= req_we;
            reg_q <= req_reg;
            len_q <= req_len_m1;
         end

         if (state == S_CMD) begin
            ca_q <= ca_q << 8;
            if (cnt == CW'(2)) lat2x <= (FIXED_LATENCY != 0) || hbus_rwds_i;
         end

         if (state == S_CMD || state == S_LAT) begin
            wph  <= 1'b0;
            wcnt <= '0;
            tmo  <= TW'(TIMEOUT);
         end

         if (state == S_WRITE) begin
            if (!wph && wdat_valid) begin
               wph <= 1'b1;
               wlo <= wdat[7:0];
               mlo <= wmask[0];
            end else if (wph) begin
               wph  <= 1'b0;
               wcnt <= wcnt + 1'b1;
            end
         end

         if (state == S_READ) begin
            if (rwds_edge) begin
               tmo <= TW'(TIMEOUT);
               if (hbus_rwds_i) rd_hi <= hbus_dq_i;
               else begin
                  rdat <= {rd_hi, hbus_dq_i};
                  wcnt <= wcnt + 1'b1;
               end
            end else begin
               tmo <= tmo - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Directed bench: small HyperBus device model plus queues of expected DQ beats, RWDS masks and read words.
module tb_hyperbus_burst_ctrl;
   localparam int LW = 4;
   localparam int RC = 4;
   localparam int CSHI = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0, req_we = 1'b0, req_reg = 1'b0;
   logic [31:0]   req_adr = '0;
   logic [LW-1:0] req_len_m1 = '0;
   logic          wdat_valid = 1'b0;
   logic [15:0]   wdat = '0;
   logic [1:0]    wmask = '0;
   logic [7:0]    hbus_dq_i = '0;
   logic          hbus_rwds_i = 1'b0;
   logic          req_ready, wdat_ready, rdat_valid, done;
   logic [15:0]   rdat;
   logic [1:0]    status;
   logic          hbus_ck, hbus_rstn, hbus_csn, hbus_dq_oe, hbus_rwds_o, hbus_rwds_oe;
   logic [7:0]    hbus_dq_o;

   always #5 clk = ~clk;

   hyperbus_burst_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_reg(req_reg),
      .req_adr(req_adr), .req_len_m1(req_len_m1),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wmask(wmask),
      .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .status(status),
      .hbus_ck(hbus_ck), .hbus_rstn(hbus_rstn), .hbus_csn(hbus_csn),
      .hbus_dq_o(hbus_dq_o), .hbus_dq_oe(hbus_dq_oe), .hbus_dq_i(hbus_dq_i),
      .hbus_rwds_o(hbus_rwds_o), .hbus_rwds_oe(hbus_rwds_oe), .hbus_rwds_i(hbus_rwds_i)
   );

   int tests = 0, fails = 0;
   logic [15:0] dq_exp[$];   // {csn-low cycle index, byte}
   logic        rwds_exp[$];
   logic [15:0] rd_exp[$];
   logic [15:0] rd_src[$];
   logic [15:0] wr_q[$];
   int          csn_cyc, rd_cnt, rdy_cnt, oe_rw;
   bit          got_done;
   logic [1:0]  st_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [47:0] ca_of(input bit we, input bit rg, input logic [31:0] adr);
      return {~we, rg, 1'b1, adr[31:3], 13'h0000, adr[2:0]};
   endfunction

   task automatic push_ca(input logic [47:0] ca);
      for (int i = 0; i < 6; i++) dq_exp.push_back({8'(i), ca[47-8*i -: 8]});
   endtask

   // Issues one request, plays the device side and checks beats until done (or abort_t).
   task automatic run_burst(input bit we, input bit rg, input logic [31:0] adr,
                            input logic [LW-1:0] len, input logic [1:0] wm,
                            input bit rwds_ca, input int lat, input int abort_t);
      bit first = 1'b1;
      bit prev_rdy = 1'b0;
      int cur_t, r;
      csn_cyc = 0; rd_cnt = 0; rdy_cnt = 0; oe_rw = 0; got_done = 1'b0; st_done = 2'bxx;
      for (int g = 0; g < 300; g++) begin
         req_valid = first; req_we = we; req_reg = rg; req_adr = adr; req_len_m1 = len; wmask = wm;
         first = 1'b0;
         if (prev_rdy && wr_q.size() > 0) void'(wr_q.pop_front());
         wdat_valid = (wr_q.size() > 0);
         wdat = (wr_q.size() > 0) ? wr_q[0] : 16'h0000;
         cur_t = hbus_csn ? -1 : csn_cyc;
         hbus_rwds_i = 1'b0; hbus_dq_i = 8'h00;
         if (cur_t >= 0 && cur_t < 6) hbus_rwds_i = rwds_ca;
         r = cur_t - 6 - lat;
         if (cur_t >= 0 && r >= 1 && (r - 1) / 2 < rd_src.size()) begin
            hbus_rwds_i = r[0];
            hbus_dq_i = r[0] ? rd_src[(r-1)/2][15:8] : rd_src[(r-1)/2][7:0];
         end
         if (abort_t >= 0 && cur_t == abort_t) break;
         #1;
         if (!hbus_csn) begin
            csn_cyc++;
            chk("ck_phase", {31'd0, hbus_ck}, 32'(cur_t & 1));
         end
         if (!hbus_csn && hbus_dq_oe && dq_exp.size() > 0)
            chk("dq_beat", {16'h0, 8'(cur_t), hbus_dq_o}, {16'h0, dq_exp.pop_front()});
         if (hbus_rwds_oe) begin
            oe_rw++;
            if (rwds_exp.size() > 0) chk("rwds_mask", {31'd0, hbus_rwds_o}, {31'd0, rwds_exp.pop_front()});
         end
         if (rdat_valid) begin
            rd_cnt++;
            if (rd_exp.size() > 0) chk("rdat", {16'h0, rdat}, {16'h0, rd_exp.pop_front()});
         end
         prev_rdy = wdat_ready && wdat_valid;
         if (prev_rdy) rdy_cnt++;
         if (done) begin
            got_done = 1'b1;
            st_done = status;
            break;
         end
         tick();
      end
      req_valid = 1'b0; wdat_valid = 1'b0; hbus_rwds_i = 1'b0; hbus_dq_i = 8'h00;
      if (abort_t < 0) begin
         chk("done_seen", {31'd0, got_done}, 32'd1);
         chk("dq_beats_left", dq_exp.size(), 32'd0);
         dq_exp.delete(); rwds_exp.delete(); rd_exp.delete(); rd_src.delete(); wr_q.delete();
      end
   endtask

   // From the done cycle, count csn-high cycles until IDLE accepts again.
   task automatic wait_idle(input logic [1:0] st);
      int n = 1;
      chk("csn_at_done", {31'd0, hbus_csn}, 32'd1);
      for (int g = 0; g < 20; g++) begin
         tick(); #1;
         if (req_ready) break;
         n++;
      end
      chk("gap_len", n, CSHI);
      chk("status_hold", {30'd0, status}, {30'd0, st});
      tick();
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csn", {31'd0, hbus_csn}, 32'd1);
      chk("rst_outs", {24'd0, hbus_ck, hbus_dq_oe, hbus_rwds_oe, done, rdat_valid, req_ready, status},
          32'd0);
      rst = 1'b0;
      for (int i = 0; i < RC; i++) begin
         #1;
         chk("rstn_low", {30'd0, hbus_rstn, req_ready}, 32'd0);
         tick();
      end
      #1;
      chk("after_rst", {29'd0, hbus_rstn, req_ready, hbus_csn}, 32'd7);
      tick();

      // memory write, 2 words, 1x latency
      push_ca(48'h2000_0002_0000);
      dq_exp.push_back({8'd18, 8'h12}); dq_exp.push_back({8'd19, 8'h34});
      dq_exp.push_back({8'd20, 8'h56}); dq_exp.push_back({8'd21, 8'h78});
      rwds_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
      wr_q = '{16'h1234, 16'h5678};
      run_burst(1'b1, 1'b0, 32'h10, 4'd1, 2'b01, 1'b0, 12, -1);
      chk("wr_status", {30'd0, st_done}, 32'd0);
      chk("wr_csn_cyc", csn_cyc, 32'd22);
      chk("wr_words", rdy_cnt, 32'd2);
      wait_idle(2'b00);

      // memory read, 4 words, 2x latency requested by RWDS during CA
      push_ca(48'hA000_0000_0000);
      rd_src = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
      rd_exp = rd_src;
      run_burst(1'b0, 1'b0, 32'h0, 4'd3, 2'b00, 1'b1, 24, -1);
      chk("rd_status", {30'd0, st_done}, 32'd0);
      chk("rd_count", rd_cnt, 32'd4);
      chk("rd_csn_cyc", csn_cyc, 32'd39);
      wait_idle(2'b00);

      // read with a silent device -> timeout
      push_ca(ca_of(1'b0, 1'b0, 32'h1234_5678));
      run_burst(1'b0, 1'b0, 32'h1234_5678, 4'd0, 2'b00, 1'b0, 12, -1);
      chk("to_status", {30'd0, st_done}, 32'd1);
      chk("to_csn_cyc", csn_cyc, 32'd82);
      chk("to_no_rdat", rd_cnt, 32'd0);
      wait_idle(2'b01);

      // register write, zero latency, no mask
      push_ca(48'h6000_0100_0000);
      dq_exp.push_back({8'd6, 8'hBE}); dq_exp.push_back({8'd7, 8'hEF});
      wr_q = '{16'hBEEF};
      run_burst(1'b1, 1'b1, 32'h800, 4'd0, 2'b11, 1'b0, 0, -1);
      chk("reg_status", {30'd0, st_done}, 32'd0);
      chk("reg_no_rwds_oe", oe_rw, 32'd0);
      chk("reg_csn_cyc", csn_cyc, 32'd8);
      wait_idle(2'b00);

      // write underrun after 2 of 4 words
      push_ca(ca_of(1'b1, 1'b0, 32'h40));
      dq_exp.push_back({8'd18, 8'h11}); dq_exp.push_back({8'd19, 8'h22});
      dq_exp.push_back({8'd20, 8'h33}); dq_exp.push_back({8'd21, 8'h44});
      rwds_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
      wr_q = '{16'h1122, 16'h3344};
      run_burst(1'b1, 1'b0, 32'h40, 4'd3, 2'b00, 1'b0, 12, -1);
      chk("ur_status", {30'd0, st_done}, 32'd2);
      chk("ur_words", rdy_cnt, 32'd2);
      chk("ur_csn_cyc", csn_cyc, 32'd23);
      wait_idle(2'b10);

      // reset in the middle of a read
      push_ca(48'hA000_0000_0000);
      run_burst(1'b0, 1'b0, 32'h0, 4'd3, 2'b00, 1'b0, 12, 10);
      chk("abort_in_burst", {31'd0, hbus_csn}, 32'd0);
      dq_exp.delete();
      #2 rst = 1'b1;
      #1;
      chk("abort_csn", {30'd0, hbus_csn, hbus_rstn}, 32'd2);
      tick();
      chk("abort_edge", {29'd0, hbus_csn, hbus_rstn, hbus_dq_oe}, 32'd4);
      rst = 1'b0;
      repeat (RC + 1) tick();
      #1;
      chk("abort_idle", {31'd0, req_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
